// File: rtl/crack_ctrl.sv
// rtl/crack_ctrl.sv - run control, result latch and seven-segment readout for the ARC4 key cracker
//
// Launches one crack run per rising edge of start via the crack_en/crack_rdy
// handshake, latches the reported key and key_valid, and shows the result on
// six active-low seven-segment digits together with busy/done/found flags and
// an elapsed-cycle count.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start              run request (already synchronised); rising edge acts
//   crack_en           one-cycle start pulse to crack
//   crack_rdy          crack ready/idle
//   crack_key          key reported by crack
//   crack_key_valid    crack found a key
//   busy, done, found  run in progress / result latched / latched key_valid
//   key_out            latched key
//   cycles             elapsed cycles of the last or current run (saturating)
//   hex0..hex5         active-low segments {g,f,e,d,c,b,a}; hex5 = top nibble

module crack_ctrl #(
   parameter int ACK_LIMIT = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             crack_en,
   input  logic             crack_rdy,
   input  logic [23:0]      crack_key,
   input  logic             crack_key_valid,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [23:0]      key_out,
   output logic [CNT_W-1:0] cycles,
   output logic [6:0]       hex0,
   output logic [6:0]       hex1,
   output logic [6:0]       hex2,
   output logic [6:0]       hex3,
   output logic [6:0]       hex4,
   output logic [6:0]       hex5
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_RUN, S_SHOW} state_e;

   localparam int ACK_W = $clog2(ACK_LIMIT + 1);

   state_e                state_q, state_d;
   logic                  start_q;
   logic                  req;
   logic [ACK_W-1:0]      ack_q, ack_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  found_q, found_d;
   logic [23:0]           key_q, key_d;
   logic [CNT_W-1:0]      cyc_q, cyc_d;
   logic [5:0][6:0]       hex_q, hex_d;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0:    seg7 = 7'h40;
         4'h1:    seg7 = 7'h79;
         4'h2:    seg7 = 7'h24;
         4'h3:    seg7 = 7'h30;
         4'h4:    seg7 = 7'h19;
         4'h5:    seg7 = 7'h12;
         4'h6:    seg7 = 7'h02;
         4'h7:    seg7 = 7'h78;
         4'h8:    seg7 = 7'h00;
         4'h9:    seg7 = 7'h10;
         4'hA:    seg7 = 7'h08;
         4'hB:    seg7 = 7'h03;
         4'hC:    seg7 = 7'h46;
         4'hD:    seg7 = 7'h21;
         4'hE:    seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   assign req = start & ~start_q;

   always_comb begin
      state_d  = state_q;
      ack_d    = ack_q;
      busy_d   = busy_q;
      done_d   = done_q;
      found_d  = found_q;
      key_d    = key_q;
      cyc_d    = cyc_q;
      crack_en = 1'b0;

      // Elapsed count runs only while crack owns the run; it sticks at all-ones.
      if ((state_q == S_ACK || state_q == S_RUN) && cyc_q != {CNT_W{1'b1}}) begin
         cyc_d = cyc_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE, S_SHOW: begin
            if (req) begin
               busy_d  = 1'b1;
               done_d  = 1'b0;
               cyc_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // Gated by rst so the pulse drops in the same cycle reset rises.
            if (crack_rdy && !rst) begin
               crack_en = 1'b1;
               ack_d    = ACK_W'(1);
               state_d  = S_ACK;
            end
         end
         S_ACK: begin
            // ack_q counts the en cycle as 1, so the retry en lands exactly
            // ACK_LIMIT cycles after the previous one.
            if (!crack_rdy) begin
               state_d = S_RUN;
            end else if (ack_q + ACK_W'(1) == ACK_W'(ACK_LIMIT)) begin
               state_d = S_REQ;
            end else begin
               ack_d = ack_q + ACK_W'(1);
            end
         end
         S_RUN: begin
            if (crack_rdy) begin
               key_d   = crack_key;
               found_d = crack_key_valid;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_SHOW;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Display follows the registered result, one cycle behind it.
      for (int n = 0; n < 6; n++) begin
         if (done_q && !busy_q) begin
            hex_d[n] = found_q ? seg7(key_q[4*n +: 4]) : 7'h3F;
         end else begin
            hex_d[n] = 7'h7F;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         found_q <= 1'b0;
         key_q   <= '0;
         cyc_q   <= '0;
         hex_q   <= '1;
      end else begin
         state_q <= state_d;
         start_q <= start;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         found_q <= found_d;
         key_q   <= key_d;
         cyc_q   <= cyc_d;
         hex_q   <= hex_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign found   = found_q;
   assign key_out = key_q;
   assign cycles  = cyc_q;
   assign hex0    = hex_q[0];
   assign hex1    = hex_q[1];
   assign hex2    = hex_q[2];
   assign hex3    = hex_q[3];
   assign hex4    = hex_q[4];
   assign hex5    = hex_q[5];

endmodule

// File: tb/tb_crack_ctrl.sv
// tb/tb_crack_ctrl.sv - directed self-checking bench for crack_ctrl with a behavioural crack model

module tb_crack_ctrl;

   localparam int ACK_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        model_rdy;
   logic        hold_low;
   logic        crack_rdy;
   logic [23:0] crack_key;
   logic        crack_key_valid;

   logic        crack_en, busy, done, found;
   logic [23:0] key_out;
   logic [31:0] cycles;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

   logic        en2, busy2, done2, found2;
   logic [23:0] key2;
   logic [3:0]  cycles2;
   logic [6:0]  h2_0, h2_1, h2_2, h2_3, h2_4, h2_5;

   logic [6:0]  hexv [6];
   logic [6:0]  glyph [16];

   typedef struct packed {
      logic        found;
      logic [23:0] key;
      logic [31:0] cycles;
   } res_t;

   res_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   en_count = 0;
   int   viol = 0;
   int   en_stamp[$];
   logic prev_en = 1'b0;
   int   ignore_n = 0;
   logic [23:0] m_key;
   logic        m_valid;

   always #5 clk = ~clk;

   assign crack_rdy = model_rdy & ~hold_low;
   assign hexv[0] = hex0;
   assign hexv[1] = hex1;
   assign hexv[2] = hex2;
   assign hexv[3] = hex3;
   assign hexv[4] = hex4;
   assign hexv[5] = hex5;

   crack_ctrl #(.ACK_LIMIT(ACK_LIMIT), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .crack_en(crack_en),
      .crack_rdy(crack_rdy), .crack_key(crack_key), .crack_key_valid(crack_key_valid),
      .busy(busy), .done(done), .found(found), .key_out(key_out), .cycles(cycles),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
   );

   // Narrow counter copy: same stimulus, used to see saturation.
   crack_ctrl #(.ACK_LIMIT(ACK_LIMIT), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .crack_en(en2),
      .crack_rdy(crack_rdy), .crack_key(crack_key), .crack_key_valid(crack_key_valid),
      .busy(busy2), .done(done2), .found(found2), .key_out(key2), .cycles(cycles2),
      .hex0(h2_0), .hex1(h2_1), .hex2(h2_2), .hex3(h2_3), .hex4(h2_4), .hex5(h2_5)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // en monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (crack_en === 1'b1) begin
         en_count++;
         en_stamp.push_back(cyc);
         if (crack_rdy !== 1'b1) viol++;
         if (prev_en === 1'b1) viol++;
      end
      prev_en = crack_en;
   end

   // crack model: drop rdy the cycle after en, raise it 100 cycles later with the result.
   initial begin
      model_rdy = 1'b1;
      crack_key = '0;
      crack_key_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (crack_en === 1'b1 && !rst) begin
            if (ignore_n > 0) begin
               ignore_n--;
            end else begin
               @(posedge clk);
               #1 model_rdy = 1'b0;
               for (int i = 0; i < 100 && !rst; i++) @(posedge clk);
               #1;
               crack_key = m_key;
               crack_key_valid = m_valid;
               model_rdy = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic f, input logic [23:0] k, input logic [31:0] c);
      res_t e;
      e.found = f;
      e.key = k;
      e.cycles = c;
      sb.push_back(e);
   endtask

   task automatic pulse_start;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_hex_all(input string tag, input logic [6:0] exp);
      for (int n = 0; n < 6; n++) chk($sformatf("%s_hex%0d", tag, n), 64'(hexv[n]), 64'(exp));
   endtask

   task automatic check_result(input string tag);
      res_t e;
      int   n;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) chk({tag, "_done_timeout"}, 64'(done), 64'(1));
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_found"}, 64'(found), 64'(e.found));
         chk({tag, "_key"}, 64'(key_out), 64'(e.key));
         chk({tag, "_cycles"}, 64'(cycles), 64'(e.cycles));
         chk({tag, "_busy"}, 64'(busy), 64'(0));
         @(negedge clk);
         for (int d = 0; d < 6; d++) begin
            chk($sformatf("%s_hex%0d", tag, d), 64'(hexv[d]),
                64'(e.found ? glyph[e.key[4*d +: 4]] : 7'h3F));
         end
      end
   endtask

   initial begin
      int base;
      int rel;
      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      rst = 1'b1;
      start = 1'b0;
      hold_low = 1'b0;
      m_key = '0;
      m_valid = 1'b0;

      // Reset state and idle hold.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_en", 64'(crack_en), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_found", 64'(found), 64'(0));
      chk("rst_key", 64'(key_out), 64'(0));
      chk("rst_cycles", 64'(cycles), 64'(0));
      check_hex_all("rst", 7'h7F);
      repeat (20) @(negedge clk);
      chk("idle_en_count", 64'(en_count), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      check_hex_all("idle", 7'h7F);

      // Run 1: key found.
      m_key = 24'h00001E;
      m_valid = 1'b1;
      base = en_count;
      push_exp(1'b1, 24'h00001E, 32'd101);
      pulse_start;
      chk("run1_busy_set", 64'(busy), 64'(1));
      check_result("run1");
      chk("run1_en_pulses", 64'(en_count - base), 64'(1));
      chk("sat_cycles", 64'(cycles2), 64'(4'hF));

      // Run 2: started from SHOW, no key found.
      m_key = 24'hFFFFFE;
      m_valid = 1'b0;
      base = en_count;
      push_exp(1'b0, 24'hFFFFFE, 32'd101);
      pulse_start;
      chk("show_restart_done", 64'(done), 64'(0));
      check_result("run2");
      chk("run2_en_pulses", 64'(en_count - base), 64'(1));

      // Run 3: rdy low at start, first en ignored by crack.
      m_key = 24'hA5C3B7;
      m_valid = 1'b1;
      ignore_n = 1;
      @(posedge clk);
      #1 hold_low = 1'b1;
      base = en_count;
      push_exp(1'b1, 24'hA5C3B7, 32'd104);
      pulse_start;
      repeat (5) @(posedge clk);
      chk("rdy_low_no_en", 64'(en_count - base), 64'(0));
      #1 hold_low = 1'b0;
      rel = cyc;
      check_result("run3");
      chk("run3_en_pulses", 64'(en_count - base), 64'(2));
      if (en_stamp.size() >= base + 2) begin
         chk("run3_first_en", 64'(en_stamp[base]), 64'(rel));
         chk("run3_retry_en", 64'(en_stamp[base + 1]), 64'(rel + ACK_LIMIT));
      end

      // Run 4: start pulses during RUN are ignored.
      m_key = 24'h123456;
      m_valid = 1'b1;
      base = en_count;
      push_exp(1'b1, 24'h123456, 32'd101);
      pulse_start;
      repeat (10) @(negedge clk);
      pulse_start;
      repeat (3) @(negedge clk);
      pulse_start;
      check_result("run4");
      chk("run4_en_pulses", 64'(en_count - base), 64'(1));

      // Reset while showing a result.
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_show_done", 64'(done), 64'(0));
      chk("rst_show_found", 64'(found), 64'(0));
      chk("rst_show_key", 64'(key_out), 64'(0));
      chk("rst_show_cycles", 64'(cycles), 64'(0));
      check_hex_all("rst_show", 7'h7F);
      @(posedge clk);
      #1 rst = 1'b0;

      // Reset in the middle of a run.
      m_key = 24'h0BEEF0;
      base = en_count;
      pulse_start;
      repeat (20) @(negedge clk);
      chk("midrun_busy", 64'(busy), 64'(1));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrun_rst_en", 64'(crack_en), 64'(0));
      chk("midrun_rst_busy", 64'(busy), 64'(0));
      chk("midrun_rst_cycles", 64'(cycles), 64'(0));
      check_hex_all("midrun_rst", 7'h7F);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_rst_done", 64'(done), 64'(0));
      chk("post_rst_en_pulses", 64'(en_count - base), 64'(1));

      chk("sb_drained", 64'(sb.size()), 64'(0));
      chk("en_protocol_violations", 64'(viol), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
